// File: rtl/tile_palette_pipe.sv
// +--------------------------------------------------------------------------+
// | tile_palette_pipe : programmable palette + 2-stage pixel colouriser with |
// |                     frame-synchronous blinking of selected colour codes  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tile_palette_pipe #(
  parameter int          COLOR_W      = 12,
  parameter int          CODE_W       = 4,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [15:0] BLINK_MASK   = 16'h0200,
  parameter int          BLINK_ALT    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid_in,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               fg_in,
  input  logic               blank_in,
  input  logic               frame_tick,
  input  logic               wr_en,
  input  logic [CODE_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               pix_valid_out,
  output logic               blink_phase
);

  localparam int CH          = COLOR_W / 3;
  localparam int NUM_ENTRIES = 2 ** CODE_W;
  localparam int CNT_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int MW          = (CODE_W < 4) ? 4 : CODE_W;
  localparam int MASK_N      = 2 ** MW;

  localparam logic [MASK_N-1:0] C_MASK_EXT = MASK_N'(BLINK_MASK);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CODE_W-1:0] C_ALT_IDX  = CODE_W'(BLINK_ALT);

  function automatic logic [11:0] default_rgb12(input int idx);
    case (idx)
      0:       return 12'hddd;
      1:       return 12'h11b;
      2:       return 12'h0a6;
      3:       return 12'he11;
      4:       return 12'h623;
      5:       return 12'h023;
      6:       return 12'h999;
      7:       return 12'ha51;
      8:       return 12'h000;
      9:       return 12'hf00;
      10:      return 12'h111;
      11:      return 12'hfff;
      12:      return 12'h555;
      default: return 12'h000;
    endcase
  endfunction

  // Widen each 4-bit channel nibble to CH bits by repeating its bit pattern from the MSB down.
  function automatic logic [COLOR_W-1:0] expand(input logic [11:0] c12);
    logic [COLOR_W-1:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < CH; k++) begin
        r[ch*CH + CH - 1 - k] = c12[ch*4 + 3 - (k % 4)];
      end
    end
    return r;
  endfunction

  logic [COLOR_W-1:0] r_pal [NUM_ENTRIES];
  logic [COLOR_W-1:0] r_col1;
  logic [COLOR_W-1:0] r_alt1;
  logic               r_blk1;
  logic               r_blank1;
  logic               r_valid1;
  logic [CNT_W-1:0]   r_cnt;

  logic [CODE_W-1:0]  w_idx;
  logic [MW-1:0]      w_code_ext;
  logic               w_blk;

  assign w_idx      = fg_in ? code_in : '0;
  assign w_code_ext = MW'(code_in);
  assign w_blk      = fg_in & C_MASK_EXT[w_code_ext];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_pal[i] <= expand(default_rgb12(i));
      end
    end else if (wr_en) begin
      r_pal[wr_addr] <= wr_data;
    end
  end

  // Lookup reads the pre-write palette, so a same-cycle write shows up one pixel later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col1        <= '0;
      r_alt1        <= '0;
      r_blk1        <= 1'b0;
      r_blank1      <= 1'b0;
      r_valid1      <= 1'b0;
      rgb_out       <= '0;
      pix_valid_out <= 1'b0;
    end else begin
      r_col1        <= r_pal[w_idx];
      r_alt1        <= r_pal[C_ALT_IDX];
      r_blk1        <= w_blk;
      r_blank1      <= blank_in;
      r_valid1      <= pix_valid_in;
      rgb_out       <= r_blank1 ? '0 : ((r_blk1 && blink_phase) ? r_alt1 : r_col1);
      pix_valid_out <= r_valid1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (r_cnt == C_CNT_LAST) begin
        r_cnt       <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_palette_pipe.sv
// Randomised and directed bench for tile_palette_pipe against a queue-based reference model.
`default_nettype none

module tb_tile_palette_pipe;

  localparam int          BF    = 30;
  localparam int          ALT   = 10;
  localparam logic [15:0] MASK  = 16'h0200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid_in = 1'b0;
  logic [3:0]  code_in = '0;
  logic        fg_in = 1'b0;
  logic        blank_in = 1'b0;
  logic        frame_tick = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic [11:0] rgb_out;
  logic        pix_valid_out;
  logic        blink_phase;

  tile_palette_pipe #(
    .COLOR_W(12), .CODE_W(4), .BLINK_FRAMES(BF), .BLINK_MASK(MASK), .BLINK_ALT(ALT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid_in(pix_valid_in), .code_in(code_in),
    .fg_in(fg_in), .blank_in(blank_in), .frame_tick(frame_tick), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rgb_out(rgb_out),
    .pix_valid_out(pix_valid_out), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] col;
    logic [11:0] alt;
    logic        blk;
    logic        blank;
    logic        valid;
  } pix_t;

  logic [11:0] c_def [16] = '{12'hddd, 12'h11b, 12'h0a6, 12'he11, 12'h623, 12'h023, 12'h999,
                              12'ha51, 12'h000, 12'hf00, 12'h111, 12'hfff, 12'h555, 12'h000,
                              12'h000, 12'h000};
  logic [11:0] m_pal [16];
  pix_t        m_pipe [$];
  int          m_ticks;
  int          errors = 0;
  int          checks = 0;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pal[i] = c_def[i];
    m_ticks = 0;
    m_pipe.delete();
  endtask

  task automatic do_reset();
    pix_valid_in = 0; code_in = 0; fg_in = 0; blank_in = 0;
    frame_tick = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drives one pixel clock; returns the model's view of the outputs after that edge.
  task automatic cycle(input bit fg, input int code, input bit blank, input bit vld,
                       input bit tick, input bit we, input int wa, input logic [11:0] wd,
                       output logic [11:0] er, output bit ev, output bit ep);
    pix_t p, h;
    logic [15:0] mask;
    int idx;
    mask    = MASK;
    idx     = fg ? code : 0;
    p.col   = m_pal[idx];
    p.alt   = m_pal[ALT];
    p.blk   = fg && mask[code];
    p.blank = blank;
    p.valid = vld;
    h = '0;
    if (m_pipe.size() > 0) h = m_pipe.pop_front();
    er = h.blank ? 12'h000 : ((h.blk && ((m_ticks / BF) % 2 == 1)) ? h.alt : h.col);
    ev = h.valid;
    m_pipe.push_back(p);
    if (we) m_pal[wa] = wd;
    if (tick) m_ticks++;
    ep = ((m_ticks / BF) % 2) == 1;
    pix_valid_in = vld; code_in = code[3:0]; fg_in = fg; blank_in = blank;
    frame_tick = tick; wr_en = we; wr_addr = wa[3:0]; wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h want=000", rgb_out); end
    if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", pix_valid_out); end
    if (blink_phase !== 1'b0) begin errors++; $display("FAIL reset_phase got=%b want=0", blink_phase); end
    checks += 3;
  endtask

  task automatic test_defaults();
    logic [11:0] er; bit ev, ep;
    for (int c = 0; c < 18; c++) begin
      cycle(1'b1, c % 16, 1'b0, (c < 16) && c[0], 1'b0, 1'b0, 0, 12'h0, er, ev, ep);
      checks += 2;
      if (rgb_out !== er) begin errors++; $display("FAIL defaults_rgb c=%0d got=%h want=%h", c, rgb_out, er); end
      if (pix_valid_out !== ev) begin errors++; $display("FAIL defaults_valid c=%0d got=%b want=%b", c, pix_valid_out, ev); end
      if (c >= 1 && c <= 16) begin
        checks++;
        if (rgb_out !== c_def[c-1]) begin errors++; $display("FAIL default_table code=%0d got=%h want=%h", c-1, rgb_out, c_def[c-1]); end
      end
    end
  endtask

  task automatic test_background_blank();
    logic [11:0] er; bit ev, ep;
    logic [11:0] want [4] = '{12'h000, 12'hddd, 12'h000, 12'h000};
    bit fgs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit bls [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int cds [4] = '{5, 3, 11, 0};
    for (int i = 0; i < 4; i++) begin
      cycle(fgs[i], cds[i], bls[i], 1'b1, 1'b0, 1'b0, 0, 12'h0, er, ev, ep);
      checks++;
      if (rgb_out !== er) begin errors++; $display("FAIL bg_blank_model i=%0d got=%h want=%h", i, rgb_out, er); end
      if (i >= 1) begin
        checks++;
        if (rgb_out !== want[i]) begin errors++; $display("FAIL bg_blank_const i=%0d got=%h want=%h", i, rgb_out, want[i]); end
      end
    end
  endtask

  task automatic test_write_collision();
    logic [11:0] er; bit ev, ep;
    cycle(1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b1, 4, 12'h0f0, er, ev, ep);
    cycle(1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0, 0, 12'h0, er, ev, ep);
    checks += 2;
    if (rgb_out !== er) begin errors++; $display("FAIL collision_model got=%h want=%h", rgb_out, er); end
    if (rgb_out !== 12'h623) begin errors++; $display("FAIL collision_old got=%h want=623", rgb_out); end
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 12'h0, er, ev, ep);
    checks += 2;
    if (rgb_out !== er) begin errors++; $display("FAIL collision_model2 got=%h want=%h", rgb_out, er); end
    if (rgb_out !== 12'h0f0) begin errors++; $display("FAIL collision_new got=%h want=0f0", rgb_out); end
  endtask

  task automatic test_blink();
    logic [11:0] er; bit ev, ep;
    do_reset();
    for (int t = 1; t <= 60; t++) begin
      cycle(1'b1, 9, 1'b0, 1'b1, 1'b0, 1'b0, 0, 12'h0, er, ev, ep);
      checks++;
      if (rgb_out !== er) begin errors++; $display("FAIL blink_model t=%0d got=%h want=%h", t, rgb_out, er); end
      cycle(1'b1, 3, 1'b0, 1'b1, 1'b1, 1'b0, 0, 12'h0, er, ev, ep);
      checks += 2;
      if (rgb_out !== er) begin errors++; $display("FAIL blink_model_tick t=%0d got=%h want=%h", t, rgb_out, er); end
      if (blink_phase !== ep) begin errors++; $display("FAIL blink_phase t=%0d got=%b want=%b", t, blink_phase, ep); end
      if (t == 30 || t == 60) begin
        cycle(1'b1, 9, 1'b0, 1'b1, 1'b0, 1'b0, 0, 12'h0, er, ev, ep);
        checks++;
        if (rgb_out !== 12'he11) begin errors++; $display("FAIL blink_code3 t=%0d got=%h want=e11", t, rgb_out); end
        cycle(1'b1, 9, 1'b0, 1'b1, 1'b0, 1'b0, 0, 12'h0, er, ev, ep);
        checks++;
        if (rgb_out !== ((t == 30) ? 12'h111 : 12'hf00)) begin
          errors++; $display("FAIL blink_toggle t=%0d got=%h want=%h", t, rgb_out, (t == 30) ? 12'h111 : 12'hf00);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] er; bit ev, ep;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15), 12'($urandom), er, ev, ep);
      checks += 3;
      if (rgb_out !== er) begin errors++; $display("FAIL random_rgb i=%0d got=%h want=%h", i, rgb_out, er); end
      if (pix_valid_out !== ev) begin errors++; $display("FAIL random_valid i=%0d got=%b want=%b", i, pix_valid_out, ev); end
      if (blink_phase !== ep) begin errors++; $display("FAIL random_phase i=%0d got=%b want=%b", i, blink_phase, ep); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [11:0] er; bit ev, ep;
    cycle(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 12'h123, er, ev, ep);
    for (int i = 0; i < 3; i++) cycle(1'b0, 7, 1'b0, 1'b1, 1'b0, 1'b0, 0, 12'h0, er, ev, ep);
    checks++;
    if (rgb_out !== 12'h123) begin errors++; $display("FAIL midrst_written got=%h want=123", rgb_out); end
    rst_n = 1'b0;
    #2;
    checks += 2;
    if (rgb_out !== 12'h000) begin errors++; $display("FAIL midrst_async_rgb got=%h want=000", rgb_out); end
    if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_async_valid got=%b want=0", pix_valid_out); end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 0, 12'h0, er, ev, ep);
      checks++;
      if (rgb_out !== er) begin errors++; $display("FAIL midrst_model i=%0d got=%h want=%h", i, rgb_out, er); end
    end
    checks += 2;
    if (rgb_out !== 12'hddd) begin errors++; $display("FAIL midrst_default got=%h want=ddd", rgb_out); end
    if (blink_phase !== 1'b0) begin errors++; $display("FAIL midrst_phase got=%b want=0", blink_phase); end
  endtask

  initial begin
    model_reset();
    #3;
    test_reset();
    do_reset();
    test_defaults();
    test_background_blank();
    test_write_collision();
    test_blink();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
